// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with per-entry direction state and a registered prediction
// Define BRANCH_PREDICTOR_2BIT_EN for 2-bit saturating counters; otherwise a 1-bit last-outcome flag.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        query_valid_i,
    input  logic [31:0] query_pc_i,
    output logic        pred_valid_o,
    output logic        pred_hit_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic [31:0] update_target_i
);

    localparam int TAG_W = 30 - IDX_W;
`ifdef BRANCH_PREDICTOR_2BIT_EN
    localparam int CTR_W = 2;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;
`else
    localparam int CTR_W = 1;
    localparam logic [CTR_W-1:0] CTR_ALLOC = 1'b1;
`endif

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [29:0]        tgt_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem [ENTRIES];

    logic [IDX_W-1:0] q_idx;
    logic [TAG_W-1:0] q_tag;
    logic             q_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             write_en;
    logic [CTR_W-1:0] ctr_next;
    logic             unused_low_bits;

    assign q_idx = query_pc_i[IDX_W+1:2];
    assign q_tag = query_pc_i[31:IDX_W+2];
    assign q_hit = valid[q_idx] && (tag_mem[q_idx] == q_tag);

    assign u_idx = update_pc_i[IDX_W+1:2];
    assign u_tag = update_pc_i[31:IDX_W+2];
    assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

    // Training is suppressed by reset and by flush (flush drops a same-cycle update).
    assign write_en = update_valid_i && !rst_i && !flush_i;

    assign unused_low_bits = ^{query_pc_i[1:0], update_pc_i[1:0], update_target_i[1:0]};

`ifdef BRANCH_PREDICTOR_2BIT_EN
    // Saturating step of the resolved entry's counter toward the resolved direction.
    always_comb begin
        ctr_next = ctr_mem[u_idx];
        if (update_taken_i) begin
            if (ctr_mem[u_idx] != 2'b11) ctr_next = ctr_mem[u_idx] + 2'd1;
        end else begin
            if (ctr_mem[u_idx] != 2'b00) ctr_next = ctr_mem[u_idx] - 2'd1;
        end
    end
`else
    assign ctr_next = update_taken_i;
`endif

    // Valid bits: cleared by reset or flush, set when a taken miss allocates.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            valid <= '0;
        end else if (update_valid_i && !u_hit && update_taken_i) begin
            valid[u_idx] <= 1'b1;
        end
    end

    // Entry payload: train on a hit, allocate on a taken miss, ignore a not-taken miss.
    always_ff @(posedge clk_i) begin
        if (write_en) begin
            if (u_hit) begin
                ctr_mem[u_idx] <= ctr_next;
                if (update_taken_i) tgt_mem[u_idx] <= update_target_i[31:2];
            end else if (update_taken_i) begin
                tag_mem[u_idx] <= u_tag;
                tgt_mem[u_idx] <= update_target_i[31:2];
                ctr_mem[u_idx] <= CTR_ALLOC;
            end
        end
    end

    // Registered prediction; table is read before this edge's update, so no bypass.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            pred_valid_o  <= 1'b0;
            pred_hit_o    <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else if (!stall_i) begin
            pred_valid_o  <= query_valid_i;
            pred_hit_o    <= query_valid_i && q_hit;
            pred_taken_o  <= query_valid_i && q_hit && ctr_mem[q_idx][CTR_W-1];
            pred_target_o <= (query_valid_i && q_hit) ? {tgt_mem[q_idx], 2'b00} : 32'd0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - randomized and directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, flush_i, query_valid_i, update_valid_i, update_taken_i;
    logic [31:0] query_pc_i, update_pc_i, update_target_i;
    logic        pred_valid_o, pred_hit_o, pred_taken_o;
    logic [31:0] pred_target_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .query_valid_i(query_valid_i), .query_pc_i(query_pc_i),
        .pred_valid_o(pred_valid_o), .pred_hit_o(pred_hit_o),
        .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
        .update_taken_i(update_taken_i), .update_target_i(update_target_i)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: 64 lines keyed by pc/4 mod 64, tag is pc/256, state is an integer strength.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_state [64];
    logic        e_valid = 0, e_hit = 0, e_taken = 0;
    logic [31:0] e_tgt = 0;

    function automatic bit predicts_taken(input int s);
`ifdef BRANCH_PREDICTOR_2BIT_EN
        return s >= 2;
`else
        return s == 1;
`endif
    endfunction

    function automatic int trained(input int s, input bit t);
`ifdef BRANCH_PREDICTOR_2BIT_EN
        if (t) return (s == 3) ? 3 : s + 1;
        return (s == 0) ? 0 : s - 1;
`else
        return t ? 1 : 0;
`endif
    endfunction

    function automatic int alloc_state();
`ifdef BRANCH_PREDICTOR_2BIT_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    always @(posedge clk) begin
        int  qi, ui;
        bit  qh, uh;
        if (rst_i || flush_i) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
            e_valid = 0; e_hit = 0; e_taken = 0; e_tgt = 0;
        end else begin
            qi = int'((query_pc_i / 4) % 64);
            ui = int'((update_pc_i / 4) % 64);
            qh = query_valid_i && m_valid[qi] && (m_tag[qi] == query_pc_i / 256);
            uh = m_valid[ui] && (m_tag[ui] == update_pc_i / 256);
            if (!stall_i) begin
                e_valid = query_valid_i;
                e_hit   = qh;
                e_taken = qh && predicts_taken(m_state[qi]);
                e_tgt   = qh ? m_tgt[qi] : 32'd0;
            end
            if (update_valid_i) begin
                if (uh) begin
                    m_state[ui] = trained(m_state[ui], update_taken_i);
                    if (update_taken_i) m_tgt[ui] = update_target_i & 32'hFFFF_FFFC;
                end else if (update_taken_i) begin
                    m_valid[ui] = 1;
                    m_tag[ui]   = update_pc_i / 256;
                    m_tgt[ui]   = update_target_i & 32'hFFFF_FFFC;
                    m_state[ui] = alloc_state();
                end
            end
        end
    end

    // Every cycle's outputs are compared against the model away from the rising edge.
    always @(negedge clk) begin
        chk("model_valid",  {31'd0, pred_valid_o}, {31'd0, e_valid});
        chk("model_hit",    {31'd0, pred_hit_o},   {31'd0, e_hit});
        chk("model_taken",  {31'd0, pred_taken_o}, {31'd0, e_taken});
        chk("model_target", pred_target_o, e_tgt);
    end

    task automatic step(input logic r, input logic f, input logic s,
                        input logic qv, input logic [31:0] qpc,
                        input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt);
        rst_i = r; flush_i = f; stall_i = s;
        query_valid_i = qv; query_pc_i = qpc;
        update_valid_i = uv; update_pc_i = upc;
        update_taken_i = ut; update_target_i = utgt;
        @(posedge clk);
        #1;
    endtask

    task automatic q(input logic [31:0] pc);
        step(0, 0, 0, 1, pc, 0, 0, 0, 0);
    endtask

    task automatic u(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        step(0, 0, 0, 0, 0, 1, pc, t, tgt);
    endtask

    task automatic expect_pred(input string name, input logic v, input logic h,
                               input logic t, input logic [31:0] tgt);
        chk({name, "_valid"},  {31'd0, pred_valid_o}, {31'd0, v});
        chk({name, "_hit"},    {31'd0, pred_hit_o},   {31'd0, h});
        chk({name, "_taken"},  {31'd0, pred_taken_o}, {31'd0, t});
        chk({name, "_target"}, pred_target_o, tgt);
    endtask

    initial begin
        logic walk_taken;
        step(1, 0, 0, 1, 32'h1000, 1, 32'h1000, 1, 32'h0F00);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_pred("reset", 0, 0, 0, 0);

        q(32'h0000_1000);
        expect_pred("cold_query", 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_pred("no_query", 0, 0, 0, 0);

        u(32'h1000, 1, 32'h0F00);
        q(32'h1000);
        expect_pred("trained", 1, 1, 1, 32'h0F00);

        u(32'h1000, 0, 32'h0);
        u(32'h1000, 0, 32'h0);
        q(32'h1000);
        expect_pred("walk_nt_nt", 1, 1, 0, 32'h0F00);
        u(32'h1000, 1, 32'h0F00);
        q(32'h1000);
`ifdef BRANCH_PREDICTOR_2BIT_EN
        walk_taken = 1'b0;
`else
        walk_taken = 1'b1;
`endif
        expect_pred("walk_one_t", 1, 1, walk_taken, 32'h0F00);
        u(32'h1000, 1, 32'h0F00);
        q(32'h1000);
        expect_pred("walk_two_t", 1, 1, 1, 32'h0F00);

        q(32'h1100);
        expect_pred("alias_miss", 1, 0, 0, 0);
        u(32'h1100, 1, 32'h2000);
        q(32'h1100);
        expect_pred("alias_new", 1, 1, 1, 32'h2000);
        q(32'h1000);
        expect_pred("alias_old", 1, 0, 0, 0);

        for (int i = 0; i < 4; i++) u(32'h3000 + 32'(4 * i), 1, 32'h8000 + 32'(16 * i));
        q(32'h3008);
        expect_pred("pre_flush", 1, 1, 1, 32'h8020);
        step(0, 1, 0, 1, 32'h3000, 0, 0, 0, 0);
        expect_pred("during_flush", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            q(32'h3000 + 32'(4 * i));
            expect_pred("post_flush", 1, 0, 0, 0);
        end
        step(0, 1, 0, 0, 0, 1, 32'h4000, 1, 32'h4400);
        q(32'h4000);
        expect_pred("flush_drops_update", 1, 0, 0, 0);

        u(32'h5000, 1, 32'h6000);
        q(32'h5000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 32'h9000 + 32'(4 * i), 0, 0, 0, 0);
            expect_pred("stall_hold", 1, 1, 1, 32'h6000);
        end
        step(0, 0, 0, 1, 32'h5000, 1, 32'h5000, 1, 32'h7000);
        expect_pred("no_bypass", 1, 1, 1, 32'h6000);
        q(32'h5000);
        expect_pred("after_update", 1, 1, 1, 32'h7000);

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] qpc, upc;
            qpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0, qpc,
                 $urandom_range(0, 1) == 1, upc, $urandom_range(0, 9) < 6, $urandom);
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch predictor: the prediction counterpart of the execute-stage `branch` comparator. It holds a direct-mapped branch target buffer with per-entry direction counters, is queried with the fetch PC, and returns a registered taken/target prediction one cycle later. The execute stage trains it with each resolved outcome (`do_branch`) and the computed target. The predictor sits beside the fetch PC mux; the mispredict redirect logic is outside this block.

## Interface
- `ENTRIES`, 64: number of BTB entries; must be a power of two, 4..1024.
- `IDX_W`, `$clog2(ENTRIES)`: index width, derived; do not override.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset; synchronous, active-high.
- `stall_i`  input  1  fetch stall; holds the registered prediction outputs.
- `flush_i`  input  1  invalidates all entries.
- `query_valid_i`  input  1  a fetch PC is presented this cycle.
- `query_pc_i`  input  32  fetch PC; bits [1:0] ignored.
- `pred_valid_o`  output  1  prediction outputs are meaningful.
- `pred_hit_o`  output  1  query PC matched a valid entry.
- `pred_taken_o`  output  1  predicted taken; equals hit AND counter MSB.
- `pred_target_o`  output  32  stored target; 0 when not hit.
- `update_valid_i`  input  1  a branch or jump resolved this cycle.
- `update_pc_i`  input  32  PC of the resolved instruction.
- `update_taken_i`  input  1  resolved direction; jumps drive 1.
- `update_target_i`  input  32  resolved target address.

## Operation
- Address split: index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`.
- Each entry holds a valid bit, a tag, a target (bits [31:2]; [1:0] are stored as 0), and a 2-bit counter. Valid bits are flops. Tag, target and counter may be inferred RAM.
- Query: hit = valid[idx] AND tag match. The result is registered into the `pred_*` outputs.
- Update with a hit (tag matches a valid entry):
  - Counter saturates up when taken and down when not taken.
  - Target is overwritten on taken updates only.
- Update with a miss:
  - Taken: allocate or replace the entry. Set valid=1, write the new tag and target, and set counter=2'b10 (weakly taken).
  - Not taken: no change to the entry.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Flush: clears every valid bit in one cycle. The counter and target contents are don't-care afterwards.

## Timing
- Prediction latency is 1 cycle. Outputs at edge N+1 reflect the query at edge N.
- `stall_i`=1: the `pred_*` outputs hold their values and the new query is ignored. Updates still apply.
- `query_valid_i`=0 with no stall: `pred_valid_o`=0 next cycle, and the other outputs are 0.
- An update takes effect at the edge where `update_valid_i` is sampled.
- Same-cycle query and update to the same index: the query sees the old (pre-update) entry. There is no bypass.
- `rst_i` has priority over `flush_i`, which has priority over an update. In the same cycle as flush, the update is dropped.
- Reset: all valid bits are cleared, and `pred_valid_o`, `pred_hit_o`, `pred_taken_o` and `pred_target_o` are all 0. A reset asserted mid-stream discards all learned state.
- A query during flush or reset returns the pre-flush table next cycle only if `rst_i`/`flush_i` has deasserted. Otherwise the result is miss with `pred_valid_o`=0.

## Configuration
- `BRANCH_PREDICTOR_2BIT_EN`
  - Defined: 2-bit saturating counters as described above.
  - Undefined: each entry holds a 1-bit last-outcome flag instead.
    - `pred_taken_o` = hit AND flag.
    - A hit update sets the flag to `update_taken_i`.
    - An allocation sets the flag to 1.
    - The target rules are unchanged.

## Test plan
- Reset, then query 0x0000_1000 -> `pred_valid_o`=1, hit=0, taken=0, target=0.
- Update pc 0x1000 taken, target 0x0F00; next cycle query 0x1000 -> hit=1, taken=1, target 0x0F00.
- Counter walk on that entry (2-bit build):
  - After NT, NT updates: taken=0.
  - After one T: still taken=0 (counter 01).
  - After a second T: taken=1.
- Aliasing (ENTRIES=64): train 0x1000 taken, then query 0x1100 -> hit=0. Train 0x1100 taken, target 0x2000 -> 0x1100 hits and 0x1000 misses.
- Flush after training 4 entries -> all 4 queries miss. Flush and an update in the same cycle -> the update is not retained.
- Hold the `pred_*` outputs with `stall_i`=1 for 3 cycles while changing `query_pc_i` -> outputs unchanged. Same-cycle query and update to one index -> the old value is returned.
